// File: rtl/din_debounce_sync.sv
// Synchronises a raw async level and debounces it into a clean q plus one-cycle rise/fall pulses.
// Latency: q and the pulse change DEBOUNCE_CYCLES+2 edges after din settles. There is no flow control.
module din_debounce_sync #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_WIDTH       = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);

    typedef enum logic [1:0] {
        S_LOW  = 2'b00,
        S_RCHK = 2'b01,
        S_HIGH = 2'b11,
        S_FCHK = 2'b10
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 r_sync1;
    logic                 r_sync2;
    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_q;
    logic                 r_rise;
    logic                 r_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
        end
    end

    // The FSM reads only r_sync2; din never reaches it directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_LOW;
            r_cnt   <= '0;
            r_q     <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                S_LOW: begin
                    r_q <= 1'b0;
                    if (r_sync2) begin
                        r_state <= S_RCHK;
                        r_cnt   <= CNT_WIDTH'(1);
                    end else begin
                        r_cnt <= '0;
                    end
                end
                S_RCHK: begin
                    if (!r_sync2) begin
                        r_state <= S_LOW;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= S_HIGH;
                        r_cnt   <= '0;
                        r_q     <= 1'b1;
                        r_rise  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_HIGH: begin
                    r_q <= 1'b1;
                    if (!r_sync2) begin
                        r_state <= S_FCHK;
                        r_cnt   <= CNT_WIDTH'(1);
                    end else begin
                        r_cnt <= '0;
                    end
                end
                S_FCHK: begin
                    if (r_sync2) begin
                        r_state <= S_HIGH;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= S_LOW;
                        r_cnt   <= '0;
                        r_q     <= 1'b0;
                        r_fall  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_LOW;
                    r_cnt   <= '0;
                    r_q     <= 1'b0;
                end
            endcase
        end
    end

    assign q    = r_q;
    assign rise = r_rise;
    assign fall = r_fall;

endmodule

// File: tb/tb_din_debounce_sync.sv
// Bench for din_debounce_sync: directed scenarios plus random din against a sample-history model.
module tb_din_debounce_sync;

    localparam int DEB = 4;
    localparam int LAT = DEB + 2;

    logic clk = 1'b0;
    logic rst;
    logic din;
    logic q, rise, fall;

    int n_checks = 0;
    int n_fail   = 0;

    din_debounce_sync #(.DEBOUNCE_CYCLES(DEB), .CNT_WIDTH(3)) dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .q    (q),
        .rise (rise),
        .fall (fall)
    );

    always #100 clk = ~clk;

    // Reference model: history of din as seen at each edge; the debouncer observes
    // that history two edges late, and q flips once the last DEB observed samples all differ from q.
    bit   m_hist[$];
    logic m_q, m_rise, m_fall;

    function automatic bit model_flip();
        int n;
        n = m_hist.size() - 2;
        if (n < DEB) return 1'b0;
        for (int i = n - DEB; i < n; i++)
            if (m_hist[i] == m_q) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hist.delete();
            m_hist.push_back(1'b0);
            m_hist.push_back(1'b0);
            m_q    <= 1'b0;
            m_rise <= 1'b0;
            m_fall <= 1'b0;
        end else begin
            m_hist.push_back(din);
            if (model_flip()) begin
                m_q    <= ~m_q;
                m_rise <= ~m_q;
                m_fall <= m_q;
            end else begin
                m_rise <= 1'b0;
                m_fall <= 1'b0;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        din = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #50;
            n_checks++;
            if ({q, rise, fall} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_hold t=%0t q/rise/fall=%b%b%b want 000", $time, q, rise, fall);
            end
            #30;
        end
        #10 rst = 1'b0;
        for (int n = 1; n <= LAT + 2; n++) begin
            @(negedge clk);
            n_checks++;
            if (q !== (n >= LAT) || rise !== (n == LAT) || fall !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_release edge=%0d q/rise/fall=%b%b%b want %b%b0",
                         n, q, rise, fall, n >= LAT, n == LAT);
            end
        end
    endtask

    task automatic test_edge(input bit lvl);
        @(negedge clk);
        din = lvl;
        for (int n = 1; n <= LAT + 2; n++) begin
            @(negedge clk);
            n_checks++;
            if (q !== ((n >= LAT) ? lvl : !lvl) || rise !== (n == LAT && lvl) ||
                fall !== (n == LAT && !lvl)) begin
                n_fail++;
                $display("FAIL clean_edge lvl=%0d edge=%0d q/rise/fall=%b%b%b want %b%b%b",
                         lvl, n, q, rise, fall, (n >= LAT) ? lvl : !lvl,
                         n == LAT && lvl, n == LAT && !lvl);
            end
        end
    endtask

    task automatic test_bounce_reject();
        bit pat [15];
        pat = '{1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            n_checks++;
            if (q !== 1'b0 || rise !== 1'b0) begin
                n_fail++;
                $display("FAIL bounce_reject cyc=%0d q=%b rise=%b want 0 0", i, q, rise);
            end
            din = pat[i];
        end
    endtask

    task automatic test_bounce_settle();
        bit pat [5];
        int rises;
        pat = '{1, 0, 1, 0, 1};
        rises = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (q !== 1'b0 || rise !== 1'b0) begin
                n_fail++;
                $display("FAIL bounce_settle_toggle cyc=%0d q=%b rise=%b want 0 0", i, q, rise);
            end
            din = pat[i];
        end
        for (int n = 1; n <= LAT + 3; n++) begin
            @(negedge clk);
            if (rise === 1'b1) rises++;
            n_checks++;
            if (q !== (n >= LAT)) begin
                n_fail++;
                $display("FAIL bounce_settle edge=%0d q=%b want %b", n, q, n >= LAT);
            end
        end
        n_checks++;
        if (rises != 1) begin
            n_fail++;
            $display("FAIL bounce_settle_pulses got=%0d want 1", rises);
        end
    endtask

    task automatic test_reset_mid();
        test_edge(1'b0);
        @(negedge clk);
        din = 1'b1;
        repeat (4) @(posedge clk);
        #50 rst = 1'b1;
        #1;
        n_checks++;
        if ({q, rise, fall} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mid_chk q/rise/fall=%b%b%b want 000", q, rise, fall);
        end
        #100 rst = 1'b0;
        for (int n = 1; n <= LAT + 1; n++) begin
            @(negedge clk);
            n_checks++;
            if (q !== (n >= LAT) || rise !== (n == LAT)) begin
                n_fail++;
                $display("FAIL reset_mid_relatch edge=%0d q=%b rise=%b want %b %b",
                         n, q, rise, n >= LAT, n == LAT);
            end
        end
        @(posedge clk);
        #50 rst = 1'b1;
        #1;
        n_checks++;
        if (q !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async_high q=%b want 0", q);
        end
        #50 rst = 1'b0;
        for (int n = 1; n <= LAT + 1; n++) begin
            @(negedge clk);
            n_checks++;
            if (q !== (n >= LAT) || rise !== (n == LAT)) begin
                n_fail++;
                $display("FAIL reset_async_relatch edge=%0d q=%b rise=%b want %b %b",
                         n, q, rise, n >= LAT, n == LAT);
            end
        end
    endtask

    task automatic test_random();
        int cyc;
        int seg;
        cyc = 0;
        seg = 0;
        while (cyc < 1500) begin
            if (seg == 60) begin
                @(posedge clk);
                #30 rst = 1'b1;
                #1;
                n_checks++;
                if ({q, rise, fall} !== {m_q, m_rise, m_fall}) begin
                    n_fail++;
                    $display("FAIL random_reset q/rise/fall=%b%b%b want %b%b%b",
                             q, rise, fall, m_q, m_rise, m_fall);
                end
                #40 rst = 1'b0;
            end
            @(negedge clk);
            din = 1'($urandom_range(0, 1));
            for (int h = $urandom_range(1, 8); h > 0; h--) begin
                @(negedge clk);
                cyc++;
                n_checks++;
                if ({q, rise, fall} !== {m_q, m_rise, m_fall} || (rise && fall)) begin
                    n_fail++;
                    $display("FAIL random cyc=%0d q/rise/fall=%b%b%b want %b%b%b",
                             cyc, q, rise, fall, m_q, m_rise, m_fall);
                end
            end
            seg++;
        end
    endtask

    initial begin
        test_reset();
        test_edge(1'b0);
        test_edge(1'b1);
        test_edge(1'b0);
        test_bounce_reject();
        test_bounce_settle();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
